// File: rtl/debug_dump_scheduler_pkg.sv
// Shared definitions for the debug dump scheduler: select codes, FSM encoding
// and a constant-width helper.
package debug_dump_scheduler_pkg;

    localparam int SEL_W = 6;
    localparam logic [SEL_W-1:0] DEFAULT_BASE_ID = 6'b000000;
    localparam logic [SEL_W-1:0] DEFAULT_IDLE_ID = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_GAP     = 3'd4,
        ST_FINISH  = 3'd5
    } dump_state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

    // Unit k answers to base + k on the shared select bus.
    function automatic logic [SEL_W-1:0] unit_id(input logic [SEL_W-1:0] base,
                                                 input logic [SEL_W-1:0] index);
        return base + index;
    endfunction

endpackage

// File: rtl/debug_frame_fifo.sv
// Show-ahead frame buffer between the latch units and the host interface.
// A push into a full buffer is only accepted when a pop frees a slot that cycle.
module debug_frame_fifo
    import debug_dump_scheduler_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic [NB_CONTROL_FRAME-1:0] i_data,
    input  logic                        i_pop,
    output logic [NB_CONTROL_FRAME-1:0] o_head,
    output logic                        o_empty,
    output logic                        o_full,
    output logic                        o_drop
);

    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [NB_CONTROL_FRAME-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W:0]              count;
    logic                        do_push;
    logic                        do_pop;

    assign o_empty = (count == '0);
    assign o_full  = (count == FULL_COUNT);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_drop  = i_push && !do_push;
    assign o_head  = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clock) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_dump_scheduler.sv
// Walks every debug latch unit in turn, buffers the frames each one streams
// and hands them to the host interface over a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for a dump request, select bus parked on IDLE_ID
// SELECT  | unit ID driven, waiting (bounded) for its writing flag
// CAPTURE | unit streaming, one frame pushed per writing cycle
// DRAIN   | select parked, waiting for the host to empty the buffer
// GAP     | one parked cycle so the next select is a fresh edge
// FINISH  | dump complete, done pulse
module debug_dump_scheduler
    import debug_dump_scheduler_pkg::*;
#(
    parameter int               NB_CONTROL_FRAME = 32,
    parameter int               N_UNITS          = 4,
    parameter logic [SEL_W-1:0] BASE_ID          = DEFAULT_BASE_ID,
    parameter logic [SEL_W-1:0] IDLE_ID          = DEFAULT_IDLE_ID,
    parameter int               FIFO_DEPTH       = 8,
    parameter int               TIMEOUT          = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    output logic [SEL_W-1:0]            o_request_select,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_writing,
    output logic [NB_CONTROL_FRAME-1:0] o_frame,
    output logic                        o_frame_valid,
    input  logic                        i_frame_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_timeout_err,
    output logic                        o_overflow_err
);

    localparam int TMR_W = clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_UNITS - 1);

    dump_state_t      state, state_nxt;
    logic [SEL_W-1:0] sel, sel_nxt;
    logic [SEL_W-1:0] idx, idx_nxt;
    logic [TMR_W-1:0] wait_cnt, wait_nxt;
    logic             push;
    logic             timeout_set;
    logic             err_clear;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;

    debug_frame_fifo #(
        .NB_CONTROL_FRAME (NB_CONTROL_FRAME),
        .FIFO_DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (push),
        .i_data  (i_frame),
        .i_pop   (i_frame_ready),
        .o_head  (o_frame),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_drop  (fifo_drop)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ST_IDLE;
            sel            <= IDLE_ID;
            idx            <= '0;
            wait_cnt       <= '0;
            o_timeout_err  <= 1'b0;
            o_overflow_err <= 1'b0;
        end else begin
            state          <= state_nxt;
            sel            <= sel_nxt;
            idx            <= idx_nxt;
            wait_cnt       <= wait_nxt;
            o_timeout_err  <= err_clear ? 1'b0 : (o_timeout_err  | timeout_set);
            o_overflow_err <= err_clear ? 1'b0 : (o_overflow_err | fifo_drop);
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        idx_nxt     = idx;
        wait_nxt    = wait_cnt;
        push        = 1'b0;
        timeout_set = 1'b0;
        err_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_SELECT;
                    sel_nxt   = unit_id(BASE_ID, '0);
                    idx_nxt   = '0;
                    wait_nxt  = TMR_LOAD;
                    err_clear = 1'b1;
                end
            end
            ST_SELECT: begin
                if (i_writing) begin
                    push      = 1'b1;
                    state_nxt = ST_CAPTURE;
                end else if (wait_cnt <= TMR_W'(1)) begin
                    timeout_set = 1'b1;
                    sel_nxt     = IDLE_ID;
                    state_nxt   = ST_GAP;
                end else begin
                    wait_nxt = wait_cnt - TMR_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (i_writing) begin
                    push = 1'b1;
                end else begin
                    sel_nxt   = IDLE_ID;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (idx < LAST_IDX) begin
                    idx_nxt   = idx + SEL_W'(1);
                    sel_nxt   = unit_id(BASE_ID, idx + SEL_W'(1));
                    wait_nxt  = TMR_LOAD;
                    state_nxt = ST_SELECT;
                end else begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default: begin
                state_nxt = ST_IDLE;
                sel_nxt   = IDLE_ID;
            end
        endcase
    end

    assign o_request_select = sel;
    assign o_frame_valid    = !fifo_empty;
    assign o_busy           = (state != ST_IDLE);
    assign o_done           = (state == ST_FINISH);

endmodule

// File: doc/debug_dump_scheduler.md
Name: debug_dump_scheduler

Overview:
Sequences a full debug dump across N_UNITS debug latch units that share one `o_request_select` bus and one frame/writing return path. Each unit is addressed by ID BASE_ID+k. On a start pulse the block addresses each unit in turn and captures the frames that unit streams, one per cycle. It buffers them in a small FIFO and hands them to the host interface (UART framer) with a valid/ready handshake. It sits between the debug latch units and the debug interface FSM.

Parameters:
NB_CONTROL_FRAME, 32, width of a frame from the latch units and to the interface
N_UNITS, 4, number of latch units walked per dump (1..63)
BASE_ID, 6'b000000, request ID of unit 0; unit k uses BASE_ID+k
IDLE_ID, 6'b111111, select code matching no unit; must lie outside BASE_ID..BASE_ID+N_UNITS-1
FIFO_DEPTH, 8, frame buffer depth (power of 2, >= largest per-unit frame count)
TIMEOUT, 16, cycles to wait for `i_writing` after a unit is selected

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle dump request from the command decoder
o_request_select  out  6  ID driven to all latch units
i_frame  in  NB_CONTROL_FRAME  frame from the currently selected unit (OR/mux of unit outputs)
i_writing  in  1  OR of the units' writing flags
o_frame  out  NB_CONTROL_FRAME  FIFO head frame to the interface
o_frame_valid  out  1  `o_frame` holds a valid frame
i_frame_ready  in  1  interface accepts `o_frame` this cycle
o_busy  out  1  dump in progress
o_done  out  1  one-cycle pulse when the dump completes
o_timeout_err  out  1  sticky: some unit never asserted `i_writing`
o_overflow_err  out  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset (`i_reset`=0, asynchronous): state IDLE, `o_request_select`=IDLE_ID, unit index 0, FIFO empty, all 1-bit outputs 0, `o_frame`=0.
- `o_request_select` is a registered output, and all state is registered.
- States: IDLE, SELECT, CAPTURE, DRAIN, GAP, FINISH.
- IDLE:
  - `i_start`=1 -> SELECT next cycle, with `o_request_select`=BASE_ID, index 0, `o_busy`=1.
  - The start clears both error flags.
  - `i_start` is ignored in every other state.
- SELECT: holds the unit ID and counts wait cycles.
  - `i_writing`=1 -> CAPTURE, and that cycle's `i_frame` is pushed.
  - Wait count reaching TIMEOUT with no `i_writing` -> set `o_timeout_err`, go to GAP (unit skipped).
- CAPTURE: each cycle with `i_writing`=1 pushes `i_frame`.
  - The first cycle with `i_writing`=0 -> DRAIN; no push that cycle.
  - The ID stays driven throughout.
- DRAIN: `o_request_select`=IDLE_ID; wait until the FIFO is empty -> GAP.
- GAP:
  - Exactly one cycle with IDLE_ID, so that each unit sees a fresh select edge even for N_UNITS=1 repeats.
  - Index < N_UNITS-1 -> increment the index, load the next ID, go to SELECT.
  - Otherwise -> FINISH.
- FINISH: one cycle; `o_done`=1, `o_busy`=0 next, return to IDLE.
- Expected latch timing: select registered at cycle t; `i_writing` rises at t+1 or t+2. TIMEOUT must exceed 2.
- FIFO:
  - Synchronous, show-ahead. `o_frame_valid` = not empty; `o_frame` = head.
  - A pushed frame becomes visible to the interface the cycle after the push.
  - Pop when `o_frame_valid` & `i_frame_ready`.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: frame dropped, `o_overflow_err` set, count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
- The interface may drain the FIFO during SELECT/CAPTURE. Frames never reorder.
- `o_frame` and `o_frame_valid` are unaffected by the `i_start` edge. After FINISH the FIFO is empty.
- Errors stay set until the next accepted `i_start` or reset.

Decomposition:
- Shared debug package:
  - select-code constants (IDLE_ID, per-unit ID assignment);
  - state encoding localparams;
  - function clog2.
- One sub-module, debug_frame_fifo: parameters NB_CONTROL_FRAME and FIFO_DEPTH. It reports full/empty and supports simultaneous push/pop.
- The FSM, unit index, timeout counter and error flags stay in the top.

Test Plan:
- Three units (BASE_ID=0) with 32/64/96-bit inputs, `i_frame_ready` held 1, `i_start` pulse -> selects 0,IDLE,1,IDLE,2,IDLE seen. Six frames out in order (1+2+3), `o_done` pulse once, both errors 0.
- Same setup, `i_frame_ready`=0 until 20 cycles after start, FIFO_DEPTH=8 -> unit 0's single frame is held and the scheduler waits in DRAIN. All six frames delivered in order once ready rises.
- Unit 1 disconnected (`i_writing` stuck 0), TIMEOUT=16 -> unit 1 skipped after 16 cycles, `o_timeout_err`=1, unit 2's frames still delivered, `o_done` asserted.
- FIFO_DEPTH=2, unit emitting 3 frames, `i_frame_ready`=0 -> the third frame is dropped, `o_overflow_err`=1, exactly 2 frames emerge when ready rises.
- `i_reset` low mid-CAPTURE -> immediately `o_request_select`=IDLE_ID, `o_busy`=0, `o_frame_valid`=0. A fresh `i_start` after release performs a full clean dump.
- `i_start` pulsed while `o_busy`=1 -> ignored, no restart. Back-to-back dumps (start one cycle after `o_done`) give an identical frame sequence twice.
